register_13bit: RTL and testbench
=================================

// Module: register_13bit
// PURPOSE
//   13-bit parallel-load storage register with load enable and complementary outputs.
//   Holds one 13-bit field of the alarm-clock datapath (time/alarm value) between updates.
//   Provides both true (Q) and inverted (Q_n) outputs for downstream logic.
//   One clock domain. Reset is asynchronous and active-low.
// PARAMETERS
//   (none) -- width fixed at 13 bits; no parameters.
// PORTS
//   Clock   input   1   rising-edge clock
//   Clear   input   1   asynchronous active-low reset; 0 forces Q=0
//   Enable  input   1   load enable; 1 = capture D on rising Clock edge
//   D       input   13  parallel data in, D[12] = MSB
//   Q       output  13  stored value
//   Q_n     output  13  bitwise complement of Q
//   Positional instantiation order (fixed): (Q, Q_n, D, Clear, Clock, Enable).
// BEHAVIOUR
//   - Reset: Clear=0 immediately (no clock needed) drives Q=13'h0000 and Q_n=13'h1FFF.
//     Reset holds for as long as Clear=0, regardless of Clock, Enable or D.
//   - Clear has priority over Enable and over any simultaneous Clock edge.
//   - Release: Clear 0->1 changes nothing by itself; Q stays 0 until the next qualifying edge.
//   - Load: on each Clock 0->1 with Clear=1 and Enable=1, Q <= D. Latency is one edge.
//     Q_n updates at the same time as Q.
//   - Hold: on a Clock rising edge with Enable=0, Q keeps its value.
//   - No edge means no change:
//     - Clock held at 1 or 0 gives no update, even if D or Enable toggle.
//     - Enable rising while Clock=1 does not load.
//     - D changes between edges have no effect.
//   - Per-bit structure:
//     - 13 identical enabled D flip-flops share Clock, Clear and Enable.
//     - Enable is realised as a D-input mux (Enable ? D : Q), not clock gating.
//   - Invariant at all times after time zero: Q_n == ~Q (all 13 bits).
//   - Power-up before the first Clear is undefined. The system must assert Clear at start.
// TESTING
//   1. Clear=0, D=13'h01FF, toggle Clock and Enable
//      -> Q=13'h0000, Q_n=13'h1FFF throughout.
//   2. Clear=1, Enable=1, Clock 0->1 with D=13'h01FF
//      -> Q=13'h01FF, Q_n=13'h1E00 after the edge.
//   3. Then D=13'h1E3F, Enable=0, Clock 0->1
//      -> Q holds 13'h01FF.
//      Set Enable=1 while Clock=1 -> still 13'h01FF (no edge).
//   4. Clock 1->0->1 with Enable=1, D=13'h1E3F
//      -> Q=13'h1E3F, Q_n=13'h01C0.
//   5. Drop Clear to 0 mid-cycle (Clock=1, Enable=1)
//      -> Q=0 immediately, not at an edge.
//      Raise Clear -> Q stays 0 until the next enabled rising edge.
//   6. Random D/Enable over 100 edges
//      -> Q matches a reference model; Q_n == ~Q checked every cycle.

Source files
------------

// File: rtl/register_13bit.sv
// Purpose: 13-bit parallel-load register with load enable and true/inverted outputs (alarm-clock time/alarm field).
// Latency: one rising Clock edge from D to Q when Enable=1; Clear=0 zeroes Q immediately, independent of Clock.
// Backpressure: none; Enable=0 simply holds the stored value, there is no handshake.
module register_13bit (
  output logic [12:0] Q,
  output logic [12:0] Q_n,
  input  logic [12:0] D,
  input  logic        Clear,
  input  logic        Clock,
  input  logic        Enable
);

  // Next value seen by each flop: a D-input mux keeps the clock ungated
  // so all 13 bits share one clean clock and one clean clear.
  logic [12:0] d_mux;

  // Load-enable mux: recirculate the current value when not loading.
  always_comb begin
    d_mux = Q;
    if (Enable) begin
      d_mux = D;
    end
  end

  // Storage flops: Clear wins over any edge and holds Q at zero while low.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Q <= 13'h0000;
    end else begin
      Q <= d_mux;
    end
  end

  // Complement output tracks Q combinationally, so both change together.
  assign Q_n = ~Q;

endmodule

// File: tb/tb_register_13bit.sv
// Randomised and directed bench for register_13bit with a queue-based scoreboard.
// The reference model is a single stored value updated from the behavioural rules.
// A monitor process pops expectations and compares Q and Q_n whenever one is queued.
module tb_register_13bit;

  logic        Clock;
  logic        Clear;
  logic        Enable;
  logic [12:0] D;
  wire  [12:0] Q;
  wire  [12:0] Q_n;

  register_13bit dut (
    .Q      (Q),
    .Q_n    (Q_n),
    .D      (D),
    .Clear  (Clear),
    .Clock  (Clock),
    .Enable (Enable)
  );

  // Scoreboard
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Behavioural model: the value the register should currently hold
  logic [12:0] model_q;

  // Monitor: compares DUT outputs against each queued expectation
  initial begin
    logic [12:0] e;
    string       nm;
    forever begin
      wait (exp_q.size() > 0);
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (Q !== e || Q_n !== ~e) begin
        n_bad++;
        $display("FAIL %s: got Q=%h Q_n=%h, want Q=%h Q_n=%h", nm, Q, Q_n, e, ~e);
      end
    end
  end

  // Queue the model's value once outputs have settled, then let the monitor run
  task automatic expect_now(input string name);
    #1;
    exp_q.push_back(model_q);
    name_q.push_back(name);
    #1;
  endtask

  task automatic rise(input string name);
    #5;
    Clock = 1'b1;
    if (!Clear)      model_q = 13'h0000;
    else if (Enable) model_q = D;
    expect_now(name);
  endtask

  task automatic fall(input string name);
    #5;
    Clock = 1'b0;
    expect_now(name);
  endtask

  task automatic set_clear(input logic v, input string name);
    Clear = v;
    if (!v) model_q = 13'h0000;
    expect_now(name);
  endtask

  initial begin
    int drain;
    Clock   = 1'b0;
    Enable  = 1'b0;
    D       = 13'h01FF;
    Clear   = 1'b0;
    model_q = 13'h0000;

    // 1: reset holds regardless of clock, enable and data
    expect_now("reset_initial");
    Enable = 1'b1;
    rise("reset_edge_en1");
    fall("reset_fall");
    Enable = 1'b0;
    rise("reset_edge_en0");
    fall("reset_fall2");

    // 2: release does nothing by itself, then first load
    set_clear(1'b1, "release_no_change");
    Enable = 1'b1;
    D      = 13'h01FF;
    rise("load_01ff");

    // 3: hold with Enable=0; no edge means no change
    fall("fall_after_load");
    D      = 13'h1E3F;
    Enable = 1'b0;
    rise("hold_en0");
    Enable = 1'b1;
    expect_now("enable_rise_clk_high");
    D = 13'h0AAA;
    expect_now("d_change_clk_high");
    D = 13'h1E3F;

    // 4: next enabled edge loads new data
    fall("fall_before_load2");
    rise("load_1e3f");

    // 5: asynchronous clear mid-cycle, then release waits for an enabled edge
    set_clear(1'b0, "async_clear_clk_high");
    set_clear(1'b1, "release_clk_high");
    fall("released_fall");
    Enable = 1'b0;
    rise("released_edge_en0");
    fall("released_fall2");
    Enable = 1'b1;
    D      = 13'h1555;
    rise("released_load");

    // 6: random data/enable over 100 edges, with occasional clear pulses
    for (int i = 0; i < 100; i++) begin
      fall("rand_fall");
      D      = 13'($urandom);
      Enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        set_clear(1'b0, "rand_clear");
        set_clear(1'b1, "rand_release");
      end
      rise("rand_edge");
      if ($urandom_range(0, 7) == 0) begin
        D      = 13'($urandom);
        Enable = ~Enable;
        expect_now("rand_clk_high_toggle");
      end
    end

    // Drain the scoreboard with a bounded wait
    drain = 0;
    while (exp_q.size() > 0 && drain < 100) begin
      #1;
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
